// File: rtl/inst_sram_resp_pkg.sv
// Purpose: shared constants, write-buffer entry type and byte-merge helper
//          for the instruction SRAM responder.
// Contents: AW_DEF, BASE_DEF defaults; wbuf_entry_t {idx, we, data};
//           byte_merge() overlays enabled byte lanes onto a base word.
package inst_sram_resp_pkg;

   localparam int unsigned AW_DEF   = 12;
   localparam logic [31:0] BASE_DEF = 32'h1c00_0000;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned WE_W     = 4;
   // Widest possible word index in a 32-bit byte space; narrower AW is zero-extended.
   localparam int unsigned IDX_W    = 30;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [WE_W-1:0]   we;
      logic [DATA_W-1:0] data;
   } wbuf_entry_t;

   // Overlay each enabled byte lane of data onto base.
   function automatic logic [DATA_W-1:0] byte_merge(
      input logic [DATA_W-1:0] base,
      input logic [WE_W-1:0]   we,
      input logic [DATA_W-1:0] data
   );
      logic [DATA_W-1:0] res;
      res = base;
      for (int b = 0; b < int'(WE_W); b++) begin
         if (we[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/inst_sram_resp_wbuf.sv
// Purpose: 2-entry FIFO write buffer with per-entry address match and
//          oldest-first byte merge for read forwarding.
// Ports: clk, reset (sync, active high); push/push_entry enqueue; pop
//        dequeues head; full/empty status; head is the oldest entry;
//        lookup_idx/base_word in, match_c per entry and merged_c out.
module sram_wbuf
   import inst_sram_resp_pkg::*;
#(
   parameter int unsigned AW = AW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  wbuf_entry_t       push_entry,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output wbuf_entry_t       head,
   input  logic [AW-1:0]     lookup_idx,
   input  logic [DATA_W-1:0] base_word,
   output logic [1:0]        match_c,
   output logic [DATA_W-1:0] merged_c
);

   // Slot 0 is always the oldest; valid[1] implies valid[0].
   logic [1:0]  valid, valid_nxt;
   wbuf_entry_t ent [2];
   wbuf_entry_t ent_nxt [2];

   assign full  = valid[1];
   assign empty = !valid[0];
   assign head  = ent[0];

   // Pop shifts slot 1 down, then push fills the first free slot.
   always_comb begin
      valid_nxt = valid;
      ent_nxt   = ent;
      if (pop) begin
         valid_nxt[0] = valid[1];
         ent_nxt[0]   = ent[1];
         valid_nxt[1] = 1'b0;
      end
      if (push) begin
         if (!valid_nxt[0]) begin
            valid_nxt[0] = 1'b1;
            ent_nxt[0]   = push_entry;
         end else begin
            valid_nxt[1] = 1'b1;
            ent_nxt[1]   = push_entry;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) valid <= 2'b00;
      else       valid <= valid_nxt;
   end

   // Payload needs no reset; valid bits qualify it.
   always_ff @(posedge clk) begin
      ent <= ent_nxt;
   end

   // Oldest entry applied first so the youngest write wins per byte.
   always_comb begin
      merged_c = base_word;
      match_c  = 2'b00;
      for (int i = 0; i < 2; i++) begin
         match_c[i] = valid[i] && (ent[i].idx == IDX_W'(lookup_idx));
         if (match_c[i]) merged_c = byte_merge(merged_c, ent[i].we, ent[i].data);
      end
   end

endmodule

// File: rtl/inst_sram_resp.sv
// Purpose: instruction SRAM responder: 1-cycle registered reads, posted
//          byte-masked writes through a 2-entry buffer with forwarding,
//          range checking and access counters.
// Ports: clk, reset (sync, active high); sram_en/sram_we/sram_addr/
//        sram_wdata request; sram_rdata registered data; range_err pulse
//        for out-of-range accesses; rd_cnt/wr_cnt accepted access counts.
module inst_sram_resp
   import inst_sram_resp_pkg::*;
#(
   parameter int unsigned AW   = AW_DEF,
   parameter logic [31:0] BASE = BASE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sram_en,
   input  logic [WE_W-1:0]   sram_we,
   input  logic [31:0]       sram_addr,
   input  logic [DATA_W-1:0] sram_wdata,
   output logic [DATA_W-1:0] sram_rdata,
   output logic              range_err,
   output logic [31:0]       rd_cnt,
   output logic [31:0]       wr_cnt
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [31:0]       offset;
   logic              in_range;
   logic [AW-1:0]     idx;
   logic              acc, rd_acc, wr_acc, oor_acc;
   logic              pop, full, empty;
   logic [1:0]        match;
   wbuf_entry_t       head, push_entry;
   logic [DATA_W-1:0] merged;

   // Above-BASE check guards the unsigned wrap of the subtraction.
   assign offset   = sram_addr - BASE;
   assign in_range = (sram_addr >= BASE) && ((offset >> (AW + 2)) == 32'd0);
   assign idx      = offset[AW+1:2];

   assign acc     = sram_en && !reset;
   assign rd_acc  = acc && in_range && (sram_we == '0);
   assign wr_acc  = acc && in_range && (sram_we != '0);
   assign oor_acc = acc && !in_range;

   // Drain whenever the array port is free of a read; a write to a full
   // buffer therefore always drains in the same cycle it enqueues.
   assign pop = !empty && !rd_acc && !reset;

   assign push_entry = '{idx: IDX_W'(idx), we: sram_we, data: sram_wdata};

   sram_wbuf #(.AW(AW)) u_wbuf (
      .clk        (clk),
      .reset      (reset),
      .push       (wr_acc),
      .push_entry (push_entry),
      .pop        (pop),
      .full       (full),
      .empty      (empty),
      .head       (head),
      .lookup_idx (idx),
      .base_word  (mem[idx]),
      .match_c    (match),
      .merged_c   (merged)
   );

   // Byte-masked drain of the oldest buffered write; array is never reset.
   always_ff @(posedge clk) begin
      if (pop) begin
         for (int b = 0; b < int'(WE_W); b++) begin
            if (head.we[b]) mem[head.idx[AW-1:0]][8*b +: 8] <= head.data[8*b +: 8];
         end
      end
   end

   // Response data, error pulse and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         sram_rdata <= '0;
         range_err  <= 1'b0;
         rd_cnt     <= '0;
         wr_cnt     <= '0;
      end else begin
         range_err <= 1'b0;
         if (rd_acc) begin
            sram_rdata <= merged;
            rd_cnt     <= rd_cnt + 32'd1;
         end
         if (wr_acc) begin
            sram_rdata <= merged;
            wr_cnt     <= wr_cnt + 32'd1;
         end
         if (oor_acc) begin
            range_err <= 1'b1;
            if (sram_we == '0) sram_rdata <= '0;
         end
      end
   end

   // full/match are status only; referenced to keep them observable.
   logic unused_status;
   assign unused_status = full ^ (^match);

endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 SHALL have parameter AW, default 12, giving array depth as 2^AW 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h1c000000, giving the byte address of word 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port sram_en, input, 1 bit: access request this cycle.
REQ-006 SHALL have port sram_we, input, 4 bits: byte write enables; 0 means read.
REQ-007 SHALL have port sram_addr, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-008 SHALL have port sram_wdata, input, 32 bits: write data, byte lane i = bits [8i+7:8i].
REQ-009 SHALL have port sram_rdata, output, 32 bits: registered read data.
REQ-010 SHALL have port range_err, output, 1 bit: one-cycle pulse aligned with the response to an out-of-range access.
REQ-011 SHALL have ports rd_cnt and wr_cnt, output, 32 bits each: accepted in-range read and write counts.

Function
REQ-012 SHALL treat an access as in range iff BASE <= sram_addr < BASE + 4*2^AW; word index = (sram_addr - BASE) >> 2.
REQ-013 SHALL, on an in-range read (en=1, we=0) at edge N, present the word on sram_rdata after edge N and hold it until the next access: latency is exactly 1 cycle.
REQ-014 SHALL hold sram_rdata unchanged in cycles with en=0, so a stalled consumer sees stable data.
REQ-015 SHALL post in-range writes (en=1, we!=0) into a 2-entry FIFO write buffer of {word index, we, wdata}, not directly into the array.
REQ-016 SHALL, on a write, set sram_rdata to the pre-write merged word at that index (read-first).
REQ-017 SHALL form read data from array contents overlaid with every matching buffered entry, per byte, oldest first, so the youngest write wins per byte lane.
REQ-018 SHALL drain the oldest buffer entry into the array, byte-masked, in any cycle without a read access.
REQ-019 SHALL never drain in a read cycle; reads have array priority.
REQ-020 SHALL, on a write arriving while the buffer is full, drain the oldest entry and enqueue the new one in the same cycle, so the buffer never overflows.
REQ-021 SHALL, on an out-of-range read, drive sram_rdata = 32'h0 and pulse range_err for one cycle.
REQ-022 SHALL, on an out-of-range write, ignore the write, leave sram_rdata unchanged, and pulse range_err for one cycle.
REQ-023 SHALL increment rd_cnt or wr_cnt by 1 per accepted in-range read or write, wrapping modulo 2^32.
REQ-024 SHALL leave out-of-range accesses uncounted.
REQ-025 SHALL drive range_err low in all cycles other than those in REQ-021 and REQ-022.

Reset
REQ-026 SHALL, while reset=1 at a rising edge, clear sram_rdata to 0, range_err to 0, rd_cnt and wr_cnt to 0, and the buffer to empty.
REQ-027 SHALL discard pending buffered writes on reset; the array is not reset and retains previously drained contents.
REQ-028 SHALL ignore sram_en in any cycle where reset=1.

Structure
REQ-029 SHALL take AW default, BASE default and the buffer entry width {AW, 4, 32} from constants.h `defines.
REQ-030 SHALL implement the buffer as one sub-module, sram_wbuf, providing 2 entries, push/pop, full/empty and a per-entry match/merge output.
REQ-031 SHALL implement the array as a single-port behavioural reg array with byte-masked write.

Verification
REQ-032 SHALL be verified by: reset, then write word 0x1c000000 = 32'h11223344 with we=4'hF, idle 2 cycles, read 0x1c000000 -> rdata = 32'h11223344 one cycle later; wr_cnt=1, rd_cnt=1.
REQ-033 SHALL be verified by: write 0x1c000004 we=4'hF 32'hAABBCCDD, then immediately write 0x1c000004 we=4'b0010 32'h0000EE00, then read without idle -> rdata = 32'hAABBEEDD via forwarding.
REQ-034 SHALL be verified by: 3 back-to-back writes to words 0, 1, 2 with no idle cycles, then reads of all three -> all correct; the buffer never exceeds 2 entries.
REQ-035 SHALL be verified by: read 0x1bfffffc -> rdata = 0 and range_err = 1 for exactly one cycle; rd_cnt unchanged.
REQ-036 SHALL be verified by: read word 5, then hold en=0 for 4 cycles -> rdata stable across all 4 cycles.
REQ-037 SHALL be verified by: write word 3 = 32'h5 (left buffered because of continuous reads of word 9), then assert reset for 1 cycle, then read word 3 -> old array value returned, buffered write lost; counters = 0 before the read.
